spi_byte_slave: RTL and testbench



---
 rtl/spi_byte_slave.sv | 165 ++++++++++++++++
 tb/tb_spi_byte_slave.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_byte_slave
// Purpose  : SPI mode-0 slave front end. Oversamples sclk/cs_n/mosi on
//            sys_clk, assembles MSB-first bytes into data_in with a one-cycle
//            data_rdy strobe, and serialises the reply byte onto miso.
// Revision : 1.0 - initial release
// ============================================================================
module spi_byte_slave (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    output logic [7:0] data_in,
    output logic       data_rdy,
    input  logic [7:0] data_out,
    input  logic       data_latch
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Synchroniser chains: bit 0 is the first stage, bit 2 the edge-detect stage.
    logic [2:0] r_sclk_sync;
    logic [2:0] r_cs_sync;
    logic [1:0] r_mosi_sync;

    logic       w_sclk_rise;
    logic       w_sclk_fall;
    logic       w_cs_fall;
    logic       w_cs_rise;
    logic       w_mosi_s;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_bit_cnt;
    logic [2:0] w_bit_cnt_nxt;
    logic [7:0] r_rx_shift;
    logic [7:0] w_rx_shift_nxt;
    logic [7:0] r_tx_shift;
    logic [7:0] w_tx_shift_nxt;
    logic [7:0] r_tx_buf;
    logic [7:0] w_tx_buf_nxt;
    logic [7:0] r_data_in;
    logic [7:0] w_data_in_nxt;
    logic       r_data_rdy;
    logic       w_data_rdy_nxt;
    logic       r_miso;
    logic       w_miso_nxt;
    logic       r_miso_oe;

    // A latch arriving in the same cycle as a byte-boundary load goes straight
    // to the shifter instead of waiting a cycle in the buffer.
    logic [7:0] w_load_byte;

    // Bring the asynchronous pad signals into the sys_clk domain.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= 3'b000;
            r_cs_sync   <= 3'b111;
            r_mosi_sync <= 2'b00;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], sclk};
            r_cs_sync   <= {r_cs_sync[1:0], cs_n};
            r_mosi_sync <= {r_mosi_sync[0], mosi};
        end
    end

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
    assign w_cs_fall   = ~r_cs_sync[1] & r_cs_sync[2];
    assign w_cs_rise   = r_cs_sync[1] & ~r_cs_sync[2];
    assign w_mosi_s    = r_mosi_sync[1];
    assign w_load_byte = data_latch ? data_out : r_tx_buf;

    // State and datapath registers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= 3'd0;
            r_rx_shift <= 8'h00;
            r_tx_shift <= 8'h00;
            r_tx_buf   <= 8'h00;
            r_data_in  <= 8'h00;
            r_data_rdy <= 1'b0;
            r_miso     <= 1'b0;
            r_miso_oe  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx_buf   <= w_tx_buf_nxt;
            r_data_in  <= w_data_in_nxt;
            r_data_rdy <= w_data_rdy_nxt;
            r_miso     <= w_miso_nxt;
            r_miso_oe  <= ~r_cs_sync[1];
        end
    end

    // Next-state and datapath update; cs edges outrank sclk edges.
    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_rx_shift_nxt = r_rx_shift;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_buf_nxt   = w_load_byte;
        w_data_in_nxt  = r_data_in;
        w_data_rdy_nxt = 1'b0;
        w_miso_nxt     = r_miso;

        case (r_state)
            ST_IDLE: begin
                w_miso_nxt = 1'b0;
                if (w_cs_fall) begin
                    w_state_nxt    = ST_ACTIVE;
                    w_bit_cnt_nxt  = 3'd0;
                    w_tx_shift_nxt = w_load_byte;
                    w_tx_buf_nxt   = 8'h00;
                    w_miso_nxt     = w_load_byte[7];
                end
            end
            ST_ACTIVE: begin
                if (w_cs_rise) begin
                    // Any partial byte is simply dropped.
                    w_state_nxt   = ST_IDLE;
                    w_bit_cnt_nxt = 3'd0;
                    w_miso_nxt    = 1'b0;
                end else if (w_sclk_rise) begin
                    w_rx_shift_nxt = {r_rx_shift[6:0], w_mosi_s};
                    w_bit_cnt_nxt  = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_data_in_nxt  = {r_rx_shift[6:0], w_mosi_s};
                        w_data_rdy_nxt = 1'b1;
                    end
                end else if (w_sclk_fall) begin
                    if (r_bit_cnt == 3'd0) begin
                        // Byte boundary: the next reply byte starts here.
                        w_tx_shift_nxt = w_load_byte;
                        w_tx_buf_nxt   = 8'h00;
                        w_miso_nxt     = w_load_byte[7];
                    end else begin
                        w_tx_shift_nxt = {r_tx_shift[6:0], 1'b0};
                        w_miso_nxt     = r_tx_shift[6];
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign miso     = r_miso;
    assign miso_oe  = r_miso_oe;
    assign data_in  = r_data_in;
    assign data_rdy = r_data_rdy;

endmodule
`default_nettype wire

// File: tb/tb_spi_byte_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_byte_slave
// Purpose  : Self-checking bench for spi_byte_slave: a behavioural SPI master
//            plus a reply responder, checked against byte-level expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_byte_slave;

    logic       sys_clk    = 1'b0;
    logic       rst_n      = 1'b0;
    logic       sclk       = 1'b0;
    logic       cs_n       = 1'b1;
    logic       mosi       = 1'b0;
    logic       miso;
    logic       miso_oe;
    logic [7:0] data_in;
    logic       data_rdy;
    logic [7:0] data_out   = 8'h00;
    logic       data_latch = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Master-side bookkeeping (written by the main process only).
    logic [7:0] mosi_bytes[$];
    logic [7:0] exp_miso[$];
    logic [7:0] miso_cap[$];
    int         rise_cyc_q[$];
    logic [7:0] resp_src[$];
    int         force_seq = 0;
    logic [7:0] force_val = 8'h00;

    // Observed strobes (written by the monitor only).
    int         rdy_cyc_q[$];
    logic [7:0] rdy_data_q[$];

    spi_byte_slave u_dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .mosi       (mosi),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .data_in    (data_in),
        .data_rdy   (data_rdy),
        .data_out   (data_out),
        .data_latch (data_latch)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Record every cycle in which data_rdy is high, with its cycle number.
    always @(posedge sys_clk) begin
        #1;
        if (data_rdy === 1'b1) begin
            rdy_cyc_q.push_back(cyc);
            rdy_data_q.push_back(data_in);
        end
    end

    // Sole driver of data_latch/data_out: explicit requests from the main
    // process, or a reply popped from resp_src whenever data_rdy is seen.
    initial begin
        int seen;
        seen = 0;
        forever begin
            @(posedge sys_clk);
            #1;
            data_latch = 1'b0;
            if (force_seq != seen) begin
                seen       = force_seq;
                data_out   = force_val;
                data_latch = 1'b1;
            end else if (data_rdy === 1'b1 && resp_src.size() > 0) begin
                data_out   = resp_src.pop_front();
                data_latch = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic mosi_bit(input int i);
        logic [7:0] t;
        t = mosi_bytes[i / 8];
        return t[7 - (i % 8)];
    endfunction

    // Request a one-cycle latch of v while the bus is idle.
    task automatic latch_idle(input logic [7:0] v);
        @(negedge sys_clk);
        force_val = v;
        force_seq++;
        repeat (4) @(negedge sys_clk);
    endtask

    // Mode-0 master: drives mosi after each falling sclk, samples miso at the
    // end of each high phase. Optionally latches `sv` in the cs_fall cycle.
    task automatic run_frame(input int nbits, input int half, input bit sim, input logic [7:0] sv);
        logic [7:0] acc;
        acc = 8'h00;
        miso_cap.delete();
        rise_cyc_q.delete();
        @(negedge sys_clk);
        mosi = mosi_bit(0);
        cs_n = 1'b0;
        if (sim) begin
            @(posedge sys_clk);
            #2;
            force_val = sv;
            force_seq++;
            @(posedge sys_clk);
            @(posedge sys_clk);
            #1;
            chk("sim_first_bit", {31'd0, miso}, {31'd0, sv[7]});
            repeat (3) @(negedge sys_clk);
        end else begin
            repeat (4) @(negedge sys_clk);
        end
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b1;
            if (i % 8 == 7) rise_cyc_q.push_back(cyc);
            repeat (half) @(negedge sys_clk);
            acc = {acc[6:0], miso};
            if (i % 8 == 7) miso_cap.push_back(acc);
            sclk = 1'b0;
            if (i + 1 < nbits) mosi = mosi_bit(i + 1);
            repeat (half) @(negedge sys_clk);
        end
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (8) @(negedge sys_clk);
    endtask

    // Compare strobes, received data, latency and captured reply bytes.
    task automatic check_frame(input int nbits, input int base);
        int nb;
        int got;
        nb  = nbits / 8;
        got = rdy_cyc_q.size() - base;
        chk("rdy_count", got, nb);
        for (int k = 0; k < nb && k < got; k++) begin
            chk($sformatf("rx_data[%0d]", k), rdy_data_q[base + k], mosi_bytes[k]);
            chk($sformatf("rdy_latency[%0d]", k), rdy_cyc_q[base + k], rise_cyc_q[k] + 3);
        end
        for (int k = 0; k < exp_miso.size() && k < miso_cap.size(); k++)
            chk($sformatf("miso_byte[%0d]", k), miso_cap[k], exp_miso[k]);
    endtask

    initial begin
        int         base;
        logic [7:0] v;
        logic [7:0] hold;
        bit         pre;

        // Reset values.
        repeat (3) @(negedge sys_clk);
        chk("rst_data_in", data_in, 8'h00);
        chk("rst_data_rdy", data_rdy, 1'b0);
        chk("rst_miso", miso, 1'b0);
        chk("rst_miso_oe", miso_oe, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);

        // Receive two bytes at sys_clk/8; nothing latched so replies are 0.
        mosi_bytes = '{8'hA5, 8'h3C};
        exp_miso   = '{8'h00, 8'h00};
        base = rdy_cyc_q.size();
        run_frame(16, 4, 1'b0, 8'h00);
        check_frame(16, base);

        // Reply path: pre-latched 0x5A, 0xC3 on first strobe, then nothing.
        latch_idle(8'h5A);
        resp_src.push_back(8'hC3);
        mosi_bytes = '{8'h12, 8'hE7, 8'h09};
        exp_miso   = '{8'h5A, 8'hC3, 8'h00};
        base = rdy_cyc_q.size();
        run_frame(24, 4, 1'b0, 8'h00);
        check_frame(24, base);

        // Abort after 5 bits of 0xFF, then a clean 0x81 frame.
        hold       = data_in;
        mosi_bytes = '{8'hFF};
        exp_miso.delete();
        base = rdy_cyc_q.size();
        run_frame(5, 4, 1'b0, 8'h00);
        check_frame(5, base);
        chk("abort_hold", data_in, hold);
        mosi_bytes = '{8'h81};
        exp_miso   = '{8'h00};
        base = rdy_cyc_q.size();
        run_frame(8, 4, 1'b0, 8'h00);
        check_frame(8, base);
        chk("after_abort_data_in", data_in, 8'h81);

        // Latch coincident with cs_fall bypasses the buffered 0x11.
        latch_idle(8'h11);
        mosi_bytes = '{8'h42, 8'h7E};
        exp_miso   = '{8'h96, 8'h00};
        base = rdy_cyc_q.size();
        run_frame(16, 4, 1'b1, 8'h96);
        check_frame(16, base);

        // Reset in the middle of a transfer with a 0xFF reply loaded.
        latch_idle(8'hFF);
        @(negedge sys_clk);
        cs_n = 1'b0;
        mosi = 1'b1;
        repeat (6) @(negedge sys_clk);
        for (int i = 0; i < 3; i++) begin
            sclk = 1'b1;
            repeat (4) @(negedge sys_clk);
            sclk = 1'b0;
            repeat (4) @(negedge sys_clk);
        end
        chk("pre_rst_miso_oe", miso_oe, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data_in", data_in, 8'h00);
        chk("mid_rst_data_rdy", data_rdy, 1'b0);
        chk("mid_rst_miso", miso, 1'b0);
        chk("mid_rst_miso_oe", miso_oe, 1'b0);
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b1;
        base = rdy_cyc_q.size();
        for (int i = 0; i < 16; i++) begin
            sclk = 1'b1;
            repeat (4) @(negedge sys_clk);
            sclk = 1'b0;
            repeat (4) @(negedge sys_clk);
        end
        chk("idle_sclk_rdy", rdy_cyc_q.size() - base, 0);
        chk("idle_sclk_miso_oe", miso_oe, 1'b0);
        chk("idle_sclk_miso", miso, 1'b0);

        // Ratio stress at sys_clk/4: random 16-byte frames and gaps.
        for (int f = 0; f < 3; f++) begin
            repeat ($urandom_range(3, 20)) @(negedge sys_clk);
            mosi_bytes.delete();
            exp_miso.delete();
            pre = 1'($urandom_range(0, 1));
            if (pre) begin
                v = 8'($urandom);
                latch_idle(v);
                exp_miso.push_back(v);
            end else begin
                exp_miso.push_back(8'h00);
            end
            for (int k = 0; k < 16; k++) begin
                mosi_bytes.push_back(8'($urandom));
                v = 8'($urandom);
                resp_src.push_back(v);
                if (k < 15) exp_miso.push_back(v);
            end
            base = rdy_cyc_q.size();
            run_frame(128, 2, 1'b0, 8'h00);
            check_frame(128, base);
            chk("stress_resp_drained", resp_src.size(), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
